// File: rtl/genetico_pkg.sv
// genetico_pkg: chromosome geometry, frame sync pattern and loader state type
package genetico_pkg;
  localparam int NUM_LE = 28;
  localparam int LE_W = 15;
  localparam int NUM_OUT = 8;
  localparam int OUT_W = 6;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int LES_W = NUM_LE * LE_W;
  localparam int OUTS_W = NUM_OUT * OUT_W;
  localparam int PAYLOAD_W = LES_W + OUTS_W;
  localparam int CNT_W = 9;
  typedef enum logic [1:0] {HUNT, LOAD, PAR, COMMIT} state_t;
endpackage

// File: rtl/chrom_loader_if.sv
// chrom_loader_if: serial configuration stream with valid/ready handshake and abort
interface chrom_loader_if;
  logic ser_in;
  logic ser_valid;
  logic ser_ready;
  logic abort;
  modport master(output ser_in, ser_valid, abort, input ser_ready);
  modport slave(input ser_in, ser_valid, abort, output ser_ready);
endinterface

// File: rtl/chrom_loader_sync_detect.sv
// sync_detect: 8-bit sliding window that flags SYNC including the bit being shifted in
module sync_detect
  import genetico_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic shift_en,
  input  logic clr,
  output logic match
);
  logic [7:0] sr_q, sr_d, nxt;
  always_comb begin
    nxt = {sr_q[6:0], bit_in};
    sr_d = clr ? 8'h00 : shift_en ? nxt : sr_q;
    match = shift_en && (nxt == SYNC);
  end
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else sr_q <= sr_d;
  end
endmodule

// File: rtl/chrom_loader.sv
// chrom_loader: deserialises sync-framed, parity-checked chromosome frames into the active configuration
module chrom_loader
  import genetico_pkg::*;
(
  input  logic clk,
  input  logic rst,
  chrom_loader_if.slave s,
  output logic [NUM_LE-1:0][LE_W-1:0] conf_les,
  output logic [NUM_OUT-1:0][OUT_W-1:0] conf_outs,
  output logic cfg_loaded,
  output logic cfg_done,
  output logic cfg_err,
  output logic busy
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic par_q, par_d;
  logic [PAYLOAD_W-1:0] shadow_q, shadow_d;
  logic [NUM_LE-1:0][LE_W-1:0] les_q, les_d;
  logic [NUM_OUT-1:0][OUT_W-1:0] outs_q, outs_d;
  logic loaded_q, loaded_d, done_q, done_d, err_q, err_d;
  logic take, match;
  assign s.ser_ready = !rst && state_q != COMMIT;
  assign take = s.ser_valid && s.ser_ready && !s.abort;
  sync_detect u_sync (
    .clk(clk),
    .rst(rst),
    .bit_in(s.ser_in),
    .shift_en(take && state_q == HUNT),
    .clr(state_q != HUNT || s.abort),
    .match(match)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    par_d = par_q;
    shadow_d = shadow_q;
    les_d = les_q;
    outs_d = outs_q;
    loaded_d = loaded_q;
    done_d = 1'b0;
    err_d = 1'b0;
    // abort may not interrupt the one-cycle commit
    if (s.abort && state_q != COMMIT) begin
      state_d = HUNT;
      cnt_d = '0;
      par_d = 1'b0;
      shadow_d = '0;
    end else begin
      case (state_q)
        HUNT: if (match) begin
          state_d = LOAD;
          cnt_d = '0;
          par_d = 1'b0;
        end
        LOAD: if (take) begin
          shadow_d = {shadow_q[PAYLOAD_W-2:0], s.ser_in};
          par_d = par_q ^ s.ser_in;
          if (cnt_q == CNT_W'(PAYLOAD_W - 1)) state_d = PAR;
          else cnt_d = cnt_q + 1'b1;
        end
        PAR: if (take) begin
          state_d = (s.ser_in ^ par_q) ? HUNT : COMMIT;
          err_d = s.ser_in ^ par_q;
        end
        COMMIT: begin
          les_d = shadow_q[PAYLOAD_W-1:OUTS_W];
          outs_d = shadow_q[OUTS_W-1:0];
          loaded_d = 1'b1;
          done_d = 1'b1;
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      cnt_q <= '0;
      par_q <= 1'b0;
      shadow_q <= '0;
      les_q <= '0;
      outs_q <= '0;
      loaded_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      par_q <= par_d;
      shadow_q <= shadow_d;
      les_q <= les_d;
      outs_q <= outs_d;
      loaded_q <= loaded_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign conf_les = les_q;
  assign conf_outs = outs_q;
  assign cfg_loaded = loaded_q;
  assign cfg_done = done_q;
  assign cfg_err = err_q;
  assign busy = state_q != HUNT;
endmodule

// File: tb/tb_chrom_loader.sv
// tb_chrom_loader: scoreboard bench for framed serial chromosome loading
module tb_chrom_loader;
  import genetico_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_LE-1:0][LE_W-1:0] conf_les;
  logic [NUM_OUT-1:0][OUT_W-1:0] conf_outs;
  logic cfg_loaded, cfg_done, cfg_err, busy;
  logic [PAYLOAD_W-1:0] cfg_now, cur, p;
  logic [PAYLOAD_W-1:0] q[$];
  logic loaded = 1'b0;
  logic prev_ready = 1'b1;
  logic prev_rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int n_err = 0;
  chrom_loader_if ifc();
  chrom_loader dut (
    .clk(clk),
    .rst(rst),
    .s(ifc),
    .conf_les(conf_les),
    .conf_outs(conf_outs),
    .cfg_loaded(cfg_loaded),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err),
    .busy(busy)
  );
  assign cfg_now = {conf_les, conf_outs};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] obs, input logic [PAYLOAD_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // done must follow exactly the single ready-low cycle that is COMMIT
  always @(negedge clk) begin
    chk("done_after_commit", cfg_done, !prev_ready && !prev_rst);
    if (cfg_err) n_err <= n_err + 1;
    if (cfg_done) begin
      if (q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
      else chk("commit_data", cfg_now, q.pop_front());
    end
    prev_ready <= ifc.ser_ready;
    prev_rst <= rst;
  end
  task automatic send_bit(input logic b, input logic ab, input bit gaps);
    int n = 0;
    @(negedge clk);
    ifc.ser_valid = 1'b0;
    ifc.abort = 1'b0;
    if (gaps)
      while ($urandom_range(1, 0) == 1) begin
        ifc.ser_in = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
    while (!ifc.ser_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) chk("ready_timeout", 1'b0, 1'b1);
    ifc.ser_in = b;
    ifc.ser_valid = 1'b1;
    ifc.abort = ab;
    @(posedge clk);
  endtask
  task automatic send_sync(input bit gaps);
    logic [7:0] sy = SYNC;
    for (int i = 7; i >= 0; i--) send_bit(sy[i], 1'b0, gaps);
  endtask
  task automatic send_frame(input logic [PAYLOAD_W-1:0] pl, input bit bad, input bit gaps);
    send_sync(gaps);
    for (int i = PAYLOAD_W - 1; i >= 0; i--) send_bit(pl[i], 1'b0, gaps);
    if (!bad) q.push_back(pl);
    send_bit((^pl) ^ bad, 1'b0, gaps);
    @(negedge clk);
    ifc.ser_valid = 1'b0;
    if (bad) begin
      chk("err_pulse", cfg_err, 1'b1);
      chk("bad_hold", cfg_now, cur);
      chk("bad_loaded", cfg_loaded, loaded);
    end else begin
      chk("commit_ready_low", ifc.ser_ready, 1'b0);
      chk("shadow_hidden", cfg_now, cur);
      cur = pl;
      loaded = 1'b1;
      @(negedge clk);
      chk("commit_loaded", cfg_loaded, 1'b1);
    end
  endtask
  task automatic rand_payload(output logic [PAYLOAD_W-1:0] r);
    for (int i = 0; i < PAYLOAD_W; i++) r[i] = 1'($urandom_range(1, 0));
  endtask
  initial begin
    ifc.ser_in = 1'b0;
    ifc.ser_valid = 1'b0;
    ifc.abort = 1'b0;
    cur = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ifc.ser_ready, 1'b0);
    chk("rst_cfg", cfg_now, '0);
    chk("rst_loaded", cfg_loaded, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    p = '0;
    p[5:0] = 6'd9;
    send_frame(p, 1'b1, 1'b0);
    chk("bad_first_loaded", cfg_loaded, 1'b0);
    send_frame(p, 1'b0, 1'b0);
    chk("outs0_nine", conf_outs[0], 6'd9);
    chk("les_zero", conf_les, '0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    p = {4'h3, {58{8'hA5}}};
    send_frame(p, 1'b0, 1'b0);
    rand_payload(p);
    send_sync(1'b0);
    for (int i = PAYLOAD_W - 1; i >= PAYLOAD_W - 200; i--) send_bit(p[i], 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    ifc.ser_valid = 1'b0;
    ifc.abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hold", cfg_now, cur);
    send_frame(p, 1'b0, 1'b0);
    rand_payload(p);
    send_sync(1'b0);
    for (int i = PAYLOAD_W - 1; i >= PAYLOAD_W - 300; i--) send_bit(p[i], 1'b0, 1'b0);
    @(negedge clk);
    ifc.ser_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cfg", cfg_now, '0);
    chk("midrst_loaded", cfg_loaded, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    cur = '0;
    loaded = 1'b0;
    rand_payload(p);
    send_frame(p, 1'b0, 1'b1);
    rand_payload(p);
    send_frame(p, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("final_cfg", cfg_now, cur);
    chk("queue_empty", q.size(), 0);
    chk("err_count", n_err, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
